if_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core, sitting directly upstream of the decode/register-read stage of the datapath. Holds the program counter and drives the instruction-memory address. Selects the next PC from sequential, branch and jump sources. Latches the fetched instruction and PC+4 into the IF/ID register, which supports stall (hold) and flush (bubble) control from the hazard unit.

---
 rtl/if_stage_if.sv | 40 ++++
 rtl/if_stage.sv | 96 +++++++++
 2 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_stage_if                                                            |
// | Bundle for the instruction-fetch stage: hazard-unit controls, branch/  |
// | jump redirects, instruction-memory read port and IF/ID outputs.        |
// |   slave  : the fetch stage (consumes controls, drives PC and IF/ID)    |
// |   master : the surrounding core (drives controls, consumes IF/ID)      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        Branch_Taken;
  logic [31:0] Branch_Address;
  logic        Jump;
  logic [31:0] Jump_Address;
  logic [31:0] Imem_Data;
  logic [31:0] Imem_Addr;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PC_4;
  logic        IFID_Valid;
  logic        Align_Err;

  modport slave (
    input  stall, flush, Branch_Taken, Branch_Address, Jump, Jump_Address,
           Imem_Data,
    output Imem_Addr, PC, PC_4, IFID_Instruction, IFID_PC_4, IFID_Valid,
           Align_Err
  );

  modport master (
    output stall, flush, Branch_Taken, Branch_Address, Jump, Jump_Address,
           Imem_Data,
    input  Imem_Addr, PC, PC_4, IFID_Instruction, IFID_PC_4, IFID_Valid,
           Align_Err
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_stage                                                               |
// | Instruction fetch with PC register, next-PC select and IF/ID pipeline  |
// | register supporting stall (hold) and flush (bubble).                   |
// | Ports:                                                                 |
// |   clk   : rising-edge clock                                            |
// |   reset : asynchronous active-high reset                               |
// |   bus   : if_stage_if.slave (controls, imem port, PC and IF/ID outputs)|
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic   clk,
  input  wire logic   reset,
  if_stage_if.slave   bus
);

  // Low bits dropped so a misconfigured reset vector still fetches aligned.
  localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q,         pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        align_err_q,  align_err_d;

  logic [31:0] pc_4;
  logic        redirect;
  logic [31:0] target_raw;

  // Sequential successor wraps modulo 2^32 with no flag.
  assign pc_4       = pc_q + 32'd4;
  assign redirect   = bus.Branch_Taken | bus.Jump;
  // Branch outranks jump when both are asserted.
  assign target_raw = bus.Branch_Taken ? bus.Branch_Address : bus.Jump_Address;

  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    align_err_d  = align_err_q;

    if (redirect) begin
      // Redirect beats stall: the instruction in flight is squashed.
      pc_d         = {target_raw[31:2], 2'b00};
      ifid_instr_d = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
      if (target_raw[1:0] != 2'b00) begin
        align_err_d = 1'b1;
      end
    end else if (bus.flush) begin
      ifid_instr_d = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
      if (!bus.stall) begin
        pc_d = pc_4;
      end
    end else if (!bus.stall) begin
      pc_d         = pc_4;
      ifid_instr_d = bus.Imem_Data;
      ifid_pc4_d   = pc_4;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= C_RESET_PC;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      align_err_q  <= align_err_d;
    end
  end

  // Every output comes from a flop or from PC alone.
  assign bus.PC               = pc_q;
  assign bus.Imem_Addr        = pc_q;
  assign bus.PC_4             = pc_4;
  assign bus.IFID_Instruction = ifid_instr_q;
  assign bus.IFID_PC_4        = ifid_pc4_q;
  assign bus.IFID_Valid       = ifid_valid_q;
  assign bus.Align_Err        = align_err_q;

endmodule
`default_nettype wire
